multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 44 ++++
 rtl/mc_decode.sv | 33 +++
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state encoding, opcode/funct constants and datapath select encodings
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    IC_NOP, IC_ADDU, IC_SUBU, IC_JR, IC_ORI, IC_LUI,
    IC_ADDI, IC_LW, IC_SW, IC_BEQ, IC_J, IC_JAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [2:0] RSRC_ALU = 3'b000;
  localparam logic [2:0] RSRC_MEM = 3'b001;
  localparam logic [2:0] RSRC_PC4 = 3'b010;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_RA  = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to instruction class decoder
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] iclass
);

  always_comb begin
    iclass = IC_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = IC_ADDU;
          FN_SUBU: iclass = IC_SUBU;
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_NOP;
        endcase
      end
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      OP_BEQ:  iclass = IC_BEQ;
      OP_ADDI: iclass = IC_ADDI;
      OP_ORI:  iclass = IC_ORI;
      OP_LUI:  iclass = IC_LUI;
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      default: iclass = IC_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM; MULTICYCLE_OVF_CHECK_EN makes addi overflow skip write-back
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_req,
  output logic [1:0] alu_ctl,
  output logic       alu_src,
  output logic       ext_op,
  output logic [2:0] reg_src,
  output logic [1:0] reg_dst,
  output logic       npc_sel,
  output logic       j_ctl,
  output logic       jr_ctl,
  output logic       instr_done,
  output logic [2:0] state
);

  state_t     state_q, state_d;
  logic [3:0] iclass_raw;
  iclass_t    iclass;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass_raw)
  );

  assign iclass = iclass_t'(iclass_raw);
  assign state  = state_q;

`ifndef MULTICYCLE_OVF_CHECK_EN
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    alu_ctl    = ALU_ADD;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    reg_src    = RSRC_ALU;
    reg_dst    = RDST_RT;
    npc_sel    = 1'b0;
    j_ctl      = 1'b0;
    jr_ctl     = 1'b0;
    instr_done = 1'b0;

    // Reset gates every output so nothing leaks while state_q is forced to FETCH.
    if (!rst) begin
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        case (iclass)
          IC_ADDU: reg_dst = RDST_RD;
          IC_SUBU: begin alu_ctl = ALU_SUB; reg_dst = RDST_RD; end
          IC_ORI:  begin alu_ctl = ALU_OR;  alu_src = 1'b1; end
          IC_LUI:  begin alu_ctl = ALU_LUI; alu_src = 1'b1; end
          IC_ADDI, IC_SW: begin alu_src = 1'b1; ext_op = 1'b1; end
          IC_LW:   begin alu_src = 1'b1; ext_op = 1'b1; reg_src = RSRC_MEM; end
          IC_BEQ:  begin alu_ctl = ALU_SUB; ext_op = 1'b1; end
          IC_JAL:  begin reg_dst = RDST_RA; reg_src = RSRC_PC4; end
          default: ;
        endcase
      end

      case (state_q)
        ST_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
        ST_DECODE: begin
          if (iclass == IC_NOP) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (iclass)
            IC_ADDU, IC_SUBU, IC_ORI, IC_LUI: state_d = ST_WB;
            IC_ADDI: begin
`ifdef MULTICYCLE_OVF_CHECK_EN
              if (overflow) begin
                instr_done = 1'b1;
                state_d    = ST_FETCH;
              end else begin
                state_d = ST_WB;
              end
`else
              state_d = ST_WB;
`endif
            end
            IC_LW, IC_SW: state_d = ST_MEM;
            IC_JR: begin
              jr_ctl     = 1'b1;
              pc_write   = 1'b1;
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end
            IC_BEQ: begin
              npc_sel    = 1'b1;
              pc_write   = zero;
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end
            IC_J, IC_JAL: begin
              j_ctl      = 1'b1;
              pc_write   = 1'b1;
              reg_write  = (iclass == IC_JAL);
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end
            default: begin
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          mem_req   = 1'b1;
          mem_write = (iclass == IC_SW);
          if (mem_ready) begin
            if (iclass == IC_SW) begin
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl plus reset corner sequences
module tb_multicycle_ctrl;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow, mem_ready;
  logic       pc_write, ir_write, reg_write, mem_write, mem_req;
  logic [1:0] alu_ctl;
  logic       alu_src, ext_op;
  logic [2:0] reg_src;
  logic [1:0] reg_dst;
  logic       npc_sel, j_ctl, jr_ctl, instr_done;
  logic [2:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .pc_write(pc_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
    .mem_req(mem_req), .alu_ctl(alu_ctl), .alu_src(alu_src), .ext_op(ext_op),
    .reg_src(reg_src), .reg_dst(reg_dst), .npc_sel(npc_sel), .j_ctl(j_ctl),
    .jr_ctl(jr_ctl), .instr_done(instr_done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc,ir,rw,mw,mr,done,state} , {alu_ctl,alu_src,ext_op,reg_src,reg_dst,npc,j,jr}
  logic [20:0] obs;
  assign obs = {pc_write, ir_write, reg_write, mem_write, mem_req, instr_done, state,
                alu_ctl, alu_src, ext_op, reg_src, reg_dst, npc_sel, j_ctl, jr_ctl};

  localparam logic [2:0] P_F = 3'd0, P_D = 3'd1, P_E = 3'd2, P_M = 3'd3, P_W = 3'd4;
  localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_JAL = 6'b000011, O_BEQ = 6'b000100;
  localparam logic [5:0] O_ADDI = 6'b001000, O_ORI = 6'b001101, O_LUI = 6'b001111;
  localparam logic [5:0] O_LW = 6'b100011, O_SW = 6'b101011, O_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000, F_0 = 6'b000000;
  localparam logic [11:0] M_ALU = 12'hC00, M_ASRC = 12'h200, M_EXT = 12'h100, M_RSRC = 12'h0E0;
  localparam logic [11:0] M_RDST = 12'h018, M_NPC = 12'h004, M_J = 12'h002, M_JR = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        ov;
    logic        rdy;
    logic [20:0] exp;
    logic [20:0] care;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [8:0] c(input logic [5:0] en, input logic [2:0] st);
    return {en, st};
  endfunction

  function automatic logic [11:0] s(input logic [1:0] alu, input logic asrc, input logic ext,
                                    input logic [2:0] rsrc, input logic [1:0] rdst,
                                    input logic [2:0] br);
    return {alu, asrc, ext, rsrc, rdst, br};
  endfunction

  task automatic add(input string n, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic ov, input logic rdy, input logic [8:0] cv,
                     input logic [11:0] sv, input logic [11:0] sm);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.z = z; v.ov = ov; v.rdy = rdy;
    v.exp  = {cv, sv};
    v.care = {9'h1FF, sm};
    vecs.push_back(v);
  endtask

  task automatic fd(input string n, input logic [5:0] op, input logic [5:0] fn);
    add({n, ".F"}, op, fn, 1'b0, 1'b0, 1'b0, c(6'b110000, P_F), NONE, NONE);
    add({n, ".D"}, op, fn, 1'b0, 1'b0, 1'b0, c(6'b000000, P_D), NONE, NONE);
  endtask

  task automatic chk(input string n, input logic [20:0] got, input logic [20:0] exp,
                     input logic [20:0] care);
    n_cmp++;
    if (((got ^ exp) & care) != 21'd0) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (care %b)", n, got, exp, care);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;

    fd("addu", O_R, F_ADDU);
    add("addu.E", O_R, F_ADDU, 1'b0, 1'b0, 1'b0, c(6'b000000, P_E), NONE, M_ALU);
    add("addu.W", O_R, F_ADDU, 1'b0, 1'b0, 1'b0, c(6'b001001, P_W), s(2'b00, 1'b0, 1'b0, 3'b000, 2'b01, 3'b000), M_RSRC | M_RDST);
    fd("subu", O_R, F_SUBU);
    add("subu.E", O_R, F_SUBU, 1'b0, 1'b0, 1'b0, c(6'b000000, P_E), s(2'b01, 1'b0, 1'b0, 3'b000, 2'b00, 3'b000), M_ALU);
    add("subu.W", O_R, F_SUBU, 1'b0, 1'b0, 1'b0, c(6'b001001, P_W), s(2'b01, 1'b0, 1'b0, 3'b000, 2'b01, 3'b000), M_RSRC | M_RDST);
    fd("jr", O_R, F_JR);
    add("jr.E", O_R, F_JR, 1'b0, 1'b0, 1'b0, c(6'b100001, P_E), s(2'b00, 1'b0, 1'b0, 3'b000, 2'b00, 3'b001), M_JR);
    fd("ori", O_ORI, F_0);
    add("ori.E", O_ORI, F_0, 1'b0, 1'b0, 1'b0, c(6'b000000, P_E), s(2'b10, 1'b1, 1'b0, 3'b000, 2'b00, 3'b000), M_ALU | M_ASRC | M_EXT);
    add("ori.W", O_ORI, F_0, 1'b0, 1'b0, 1'b0, c(6'b001001, P_W), NONE, M_RDST | M_RSRC);
    fd("lui", O_LUI, F_0);
    add("lui.E", O_LUI, F_0, 1'b0, 1'b0, 1'b0, c(6'b000000, P_E), s(2'b11, 1'b1, 1'b0, 3'b000, 2'b00, 3'b000), M_ALU | M_ASRC | M_EXT);
    add("lui.W", O_LUI, F_0, 1'b0, 1'b0, 1'b0, c(6'b001001, P_W), NONE, M_RDST);
    fd("addi", O_ADDI, F_0);
`ifdef MULTICYCLE_OVF_CHECK_EN
    add("addi_ovf.E", O_ADDI, F_0, 1'b0, 1'b1, 1'b0, c(6'b000001, P_E), s(2'b00, 1'b0, 1'b1, 3'b000, 2'b00, 3'b000), M_ALU | M_EXT);
`else
    add("addi_ovf.E", O_ADDI, F_0, 1'b0, 1'b1, 1'b0, c(6'b000000, P_E), s(2'b00, 1'b0, 1'b1, 3'b000, 2'b00, 3'b000), M_ALU | M_EXT);
    add("addi_ovf.W", O_ADDI, F_0, 1'b0, 1'b1, 1'b0, c(6'b001001, P_W), NONE, M_RDST);
`endif
    add("lw.F", O_LW, F_0, 1'b0, 1'b0, 1'b1, c(6'b110000, P_F), NONE, NONE);
    add("lw.D", O_LW, F_0, 1'b0, 1'b0, 1'b1, c(6'b000000, P_D), NONE, NONE);
    add("lw.E", O_LW, F_0, 1'b0, 1'b0, 1'b1, c(6'b000000, P_E), NONE, NONE);
    add("lw.M1", O_LW, F_0, 1'b0, 1'b0, 1'b0, c(6'b000010, P_M), NONE, NONE);
    add("lw.M2", O_LW, F_0, 1'b0, 1'b0, 1'b0, c(6'b000010, P_M), NONE, NONE);
    add("lw.M3", O_LW, F_0, 1'b0, 1'b0, 1'b1, c(6'b000010, P_M), NONE, NONE);
    add("lw.W", O_LW, F_0, 1'b0, 1'b0, 1'b0, c(6'b001001, P_W), s(2'b00, 1'b0, 1'b0, 3'b001, 2'b00, 3'b000), M_RSRC);
    fd("sw", O_SW, F_0);
    add("sw.E", O_SW, F_0, 1'b0, 1'b0, 1'b0, c(6'b000000, P_E), NONE, NONE);
    add("sw.M", O_SW, F_0, 1'b0, 1'b0, 1'b1, c(6'b000111, P_M), NONE, NONE);
    fd("beq1", O_BEQ, F_0);
    add("beq1.E", O_BEQ, F_0, 1'b1, 1'b0, 1'b0, c(6'b100001, P_E), s(2'b01, 1'b0, 1'b0, 3'b000, 2'b00, 3'b100), M_ALU | M_NPC);
    fd("beq0", O_BEQ, F_0);
    add("beq0.E", O_BEQ, F_0, 1'b0, 1'b0, 1'b0, c(6'b000001, P_E), s(2'b01, 1'b0, 1'b0, 3'b000, 2'b00, 3'b100), M_ALU | M_NPC);
    fd("j", O_J, F_0);
    add("j.E", O_J, F_0, 1'b0, 1'b0, 1'b0, c(6'b100001, P_E), s(2'b00, 1'b0, 1'b0, 3'b000, 2'b00, 3'b010), M_J);
    fd("jal", O_JAL, F_0);
    add("jal.E", O_JAL, F_0, 1'b0, 1'b0, 1'b0, c(6'b101001, P_E), s(2'b00, 1'b0, 1'b0, 3'b010, 2'b10, 3'b010), M_RSRC | M_RDST | M_J);
    add("nop.F", O_BAD, F_0, 1'b0, 1'b0, 1'b0, c(6'b110000, P_F), NONE, NONE);
    add("nop.D", O_BAD, F_0, 1'b0, 1'b0, 1'b0, c(6'b000001, P_D), NONE, NONE);
    add("rnop.F", O_R, F_0, 1'b0, 1'b0, 1'b0, c(6'b110000, P_F), NONE, NONE);
    add("rnop.D", O_R, F_0, 1'b0, 1'b0, 1'b0, c(6'b000001, P_D), NONE, NONE);
    fd("swwait", O_SW, F_0);
    add("swwait.E", O_SW, F_0, 1'b0, 1'b0, 1'b0, c(6'b000000, P_E), NONE, NONE);
    add("swwait.M", O_SW, F_0, 1'b0, 1'b0, 1'b0, c(6'b000110, P_M), NONE, NONE);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", obs, 21'd0, 21'h1FFFFF);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z;
      overflow = vecs[i].ov; mem_ready = vecs[i].rdy;
      @(negedge clk);
      chk(vecs[i].name, obs, vecs[i].exp, vecs[i].care);
      @(posedge clk);
      #1;
    end

    // Still waiting in sw MEM: reset must drop mem_write without a clock edge.
    #2;
    chk("swwait.hold", obs, {c(6'b000110, P_M), NONE}, {9'h1FF, NONE});
    rst = 1'b1;
    #1;
    chk("async_rst", obs, 21'd0, 21'h1FFFFF);
    @(posedge clk);
    #1;
    chk("rst_over_edge", obs, 21'd0, 21'h1FFFFF);
    rst = 1'b0; opcode = O_R; funct = F_ADDU; mem_ready = 1'b0;
    @(negedge clk);
    chk("post_rst.F", obs, {c(6'b110000, P_F), NONE}, {9'h1FF, NONE});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst.D", obs, {c(6'b000000, P_D), NONE}, {9'h1FF, NONE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
